// File: rtl/fetch_decoder.sv
// Instruction fetch and decode: word-addressed instruction memory with a
// registered read port, an instruction register, and field/class decode.
module fetch_decoder #(
  parameter int unsigned MEM_DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] w_addr_32,
  input  logic [31:0] w_data_in_32,
  input  logic        rw,
  input  logic        en,
  output logic [31:0] w_data_out_32,
  output logic [31:0] w_instr_out_32,
  output logic [5:0]  w_op_type_6,
  output logic [4:0]  w_rs_addr_5,
  output logic [4:0]  w_rt_addr_5,
  output logic [4:0]  w_rd_addr_5,
  output logic [4:0]  w_sh_amt_5,
  output logic [5:0]  w_func_6,
  output logic [15:0] w_alu_imm_val_16,
  output logic [25:0] w_branch_imm_val_26,
  output logic        w_alu_op,
  output logic        w_mem_op,
  output logic        w_branch_op,
  output logic        w_nop
);

  localparam int unsigned AW = $clog2(MEM_DEPTH_WORDS);

  logic [31:0]   mem_q [MEM_DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          mem_we;
  logic [31:0]   data_out_d, data_out_q;
  logic [31:0]   ir_d, ir_q;
  logic          unused_addr_bits;

  // Byte offset and bits above the memory depth are dropped, so addresses wrap.
  assign word_idx         = w_addr_32[AW+1:2];
  assign unused_addr_bits = ^{w_addr_32[31:AW+2], w_addr_32[1:0]};

  // Stage 0: memory access and read-data register
  always_comb begin
    mem_we     = en && !rw && !reset;
    data_out_d = data_out_q;
    if (en && rw) begin
      data_out_d = mem_q[word_idx];
    end
    ir_d = data_out_q;
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[word_idx] <= w_data_in_32;
    end
  end

  // Stage 1: instruction register fed from the read-data register
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q <= 32'h0;
      ir_q       <= 32'h0;
    end else begin
      data_out_q <= data_out_d;
      ir_q       <= ir_d;
    end
  end

  assign w_data_out_32       = data_out_q;
  assign w_instr_out_32      = ir_q;
  assign w_op_type_6         = ir_q[31:26];
  assign w_rs_addr_5         = ir_q[25:21];
  assign w_rt_addr_5         = ir_q[20:16];
  assign w_rd_addr_5         = ir_q[15:11];
  assign w_sh_amt_5          = ir_q[10:6];
  assign w_func_6            = ir_q[5:0];
  assign w_alu_imm_val_16    = ir_q[15:0];
  assign w_branch_imm_val_26 = ir_q[25:0];

  // Class decode; an all-zero IR is a nop and suppresses the R-type alu class.
  always_comb begin
    logic is_zero;
    logic is_jr;
    is_zero     = (ir_q == 32'h0);
    is_jr       = (ir_q[5:0] == 6'h08) || (ir_q[5:0] == 6'h09);
    w_nop       = is_zero;
    w_alu_op    = 1'b0;
    w_mem_op    = 1'b0;
    w_branch_op = 1'b0;
    if (!is_zero) begin
      case (ir_q[31:26])
        6'h00: begin
          w_branch_op = is_jr;
          w_alu_op    = !is_jr;
        end
        6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07:
          w_branch_op = 1'b1;
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
          w_alu_op = 1'b1;
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
        6'h28, 6'h29, 6'h2A, 6'h2B:
          w_mem_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decoder.sv
// Bench for fetch_decoder: reference-model checks, class table, directed corner sequences.
module tb_fetch_decoder;

  logic        clock;
  logic        reset;
  logic [31:0] w_addr_32;
  logic [31:0] w_data_in_32;
  logic        rw;
  logic        en;
  logic [31:0] w_data_out_32;
  logic [31:0] w_instr_out_32;
  logic [5:0]  w_op_type_6;
  logic [4:0]  w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5;
  logic [5:0]  w_func_6;
  logic [15:0] w_alu_imm_val_16;
  logic [25:0] w_branch_imm_val_26;
  logic        w_alu_op, w_mem_op, w_branch_op, w_nop;

  fetch_decoder #(.MEM_DEPTH_WORDS(64)) dut (
    .clock(clock), .reset(reset), .w_addr_32(w_addr_32), .w_data_in_32(w_data_in_32),
    .rw(rw), .en(en), .w_data_out_32(w_data_out_32), .w_instr_out_32(w_instr_out_32),
    .w_op_type_6(w_op_type_6), .w_rs_addr_5(w_rs_addr_5), .w_rt_addr_5(w_rt_addr_5),
    .w_rd_addr_5(w_rd_addr_5), .w_sh_amt_5(w_sh_amt_5), .w_func_6(w_func_6),
    .w_alu_imm_val_16(w_alu_imm_val_16), .w_branch_imm_val_26(w_branch_imm_val_26),
    .w_alu_op(w_alu_op), .w_mem_op(w_mem_op), .w_branch_op(w_branch_op), .w_nop(w_nop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mdl_mem [64];
  logic [31:0] mdl_dout;
  logic [31:0] mdl_ir;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flags as {nop, alu, mem, branch}, straight from the opcode/func class rules.
  function automatic logic [3:0] classify(input logic [31:0] ir);
    logic [5:0] op, f;
    logic nop, alu, mem, br;
    op  = ir[31:26];
    f   = ir[5:0];
    nop = (ir == 32'h0);
    br  = !nop && ((op inside {[6'h01:6'h07]}) || (op == 6'h00 && (f inside {6'h08, 6'h09})));
    alu = !nop && ((op == 6'h00 && !(f inside {6'h08, 6'h09})) || (op inside {[6'h08:6'h0F]}));
    mem = op inside {[6'h20:6'h26], [6'h28:6'h2B]};
    return {nop, alu, mem, br};
  endfunction

  function automatic logic [79:0] expect_dec(input logic [31:0] ir);
    return {2'b0, ir[31:26], ir[25:21], ir[20:16], ir[15:11], ir[10:6], ir[5:0],
            ir[15:0], ir[25:0], classify(ir)};
  endfunction

  function automatic logic [79:0] dut_dec();
    return {2'b0, w_op_type_6, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5, w_func_6,
            w_alu_imm_val_16, w_branch_imm_val_26, w_nop, w_alu_op, w_mem_op, w_branch_op};
  endfunction

  // Called at a falling edge: drive, take the rising edge, advance the model, check at the next falling edge.
  task automatic step(input logic r, input logic e, input logic w_rw,
                      input logic [31:0] a, input logic [31:0] d);
    int idx;
    reset = r; en = e; rw = w_rw; w_addr_32 = a; w_data_in_32 = d;
    @(posedge clock);
    idx = int'(a[7:2]);
    if (r) begin
      mdl_dout = 32'h0;
      mdl_ir   = 32'h0;
    end else begin
      mdl_ir = mdl_dout;
      if (e && w_rw) mdl_dout = mdl_mem[idx];
      if (e && !w_rw) mdl_mem[idx] = d;
    end
    @(negedge clock);
    chk("data_out", {48'h0, w_data_out_32}, {48'h0, mdl_dout});
    chk("instr", {48'h0, w_instr_out_32}, {48'h0, mdl_ir});
    chk("decode", dut_dec(), expect_dec(mdl_ir));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d); step(0, 1, 0, a, d); endtask
  task automatic rd(input logic [31:0] a); step(0, 1, 1, a, 32'h0); endtask
  task automatic idle(); step(0, 0, 1, 32'h0, 32'h0); endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags; // {nop, alu, mem, branch}
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{32'h00851020, 4'b0100};
    tbl[1]  = '{32'h8FA40010, 4'b0010};
    tbl[2]  = '{32'h08008004, 4'b0001};
    tbl[3]  = '{32'h03E00008, 4'b0001};
    tbl[4]  = '{32'h03E00009, 4'b0001};
    tbl[5]  = '{32'h00000000, 4'b1000};
    tbl[6]  = '{32'hFC000000, 4'b0000};
    tbl[7]  = '{32'h20010005, 4'b0100};
    tbl[8]  = '{32'h3C000000, 4'b0100};
    tbl[9]  = '{32'h80000000, 4'b0010};
    tbl[10] = '{32'h9C000000, 4'b0000};
    tbl[11] = '{32'hAC000000, 4'b0010};
    tbl[12] = '{32'h04000000, 4'b0001};
    tbl[13] = '{32'h1C000000, 4'b0001};
    tbl[14] = '{32'h40000000, 4'b0000};
    tbl[15] = '{32'h00000008, 4'b0001};

    reset = 1'b1; en = 1'b0; rw = 1'b1; w_addr_32 = 32'h0; w_data_in_32 = 32'h0;
    mdl_dout = 32'h0; mdl_ir = 32'h0;
    for (int i = 0; i < 64; i++) mdl_mem[i] = 32'h0;
    @(negedge clock);

    // Reset state
    step(1, 0, 1, 32'h0, 32'h0);
    step(1, 1, 1, 32'h0, 32'h0);
    chk("reset_nop", {79'h0, w_nop}, 80'h1);
    chk("reset_flags", {77'h0, w_alu_op, w_mem_op, w_branch_op}, 80'h0);

    // Fill memory so every later read has known contents
    for (int i = 0; i < 64; i++) wr(32'(i * 4), 32'h0);

    // Never-written-since-fill word read with IR zero -> nop
    rd(32'h40); idle();
    chk("zero_nop", {76'h0, w_nop, w_alu_op, w_mem_op, w_branch_op}, {76'h0, 4'b1000});

    // Reference program words
    wr(32'h0, 32'h00851020); rd(32'h0); idle();
    chk("add_fields", {43'h0, w_alu_op, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5, w_func_6, 10'h0},
        {43'h0, 1'b1, 5'd4, 5'd5, 5'd2, 5'd0, 6'h20, 10'h0});
    wr(32'h4, 32'h8FA40010); rd(32'h4); idle();
    chk("lw_fields", {47'h0, w_mem_op, w_op_type_6, w_rs_addr_5, w_rt_addr_5, w_alu_imm_val_16},
        {47'h0, 1'b1, 6'h23, 5'd29, 5'd4, 16'h0010});
    wr(32'h8, 32'h08008004); rd(32'h8); idle();
    chk("j_fields", {47'h0, w_branch_op, w_op_type_6, w_branch_imm_val_26},
        {47'h0, 1'b1, 6'h02, 26'h0008004});
    wr(32'hC, 32'h03E00008); rd(32'hC); idle();
    chk("jr_flags", {78'h0, w_branch_op, w_alu_op}, {78'h0, 2'b10});

    // Disabled write must not disturb word 0, and data_out holds while en=0
    step(0, 0, 0, 32'h0, 32'hFFFFFFFF);
    chk("en0_hold", {48'h0, w_data_out_32}, {48'h0, 32'h03E00008});
    rd(32'h0); idle();
    chk("en0_nowrite", {48'h0, w_instr_out_32}, {48'h0, 32'h00851020});

    // Address wrap: high bits and byte offset ignored
    rd(32'hFFFF_FF07); idle();
    chk("wrap_read", {48'h0, w_instr_out_32}, {48'h0, 32'h8FA40010});

    // Reset mid-stream, with a write attempted during reset
    rd(32'h0); rd(32'h4);
    step(1, 1, 0, 32'h4, 32'hDEADBEEF);
    chk("rst_dout", {48'h0, w_data_out_32}, 80'h0);
    chk("rst_ir", {48'h0, w_instr_out_32}, 80'h0);
    chk("rst_nop", {79'h0, w_nop}, 80'h1);
    rd(32'h4); idle();
    chk("rst_mem_kept", {48'h0, w_instr_out_32}, {48'h0, 32'h8FA40010});

    // Class table
    foreach (tbl[i]) begin
      wr(32'(128 + i * 4), tbl[i].instr);
      rd(32'(128 + i * 4));
      idle();
      chk($sformatf("class[%0d]", i), {76'h0, w_nop, w_alu_op, w_mem_op, w_branch_op}, {76'h0, tbl[i].flags});
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d = 32'h0;
      if ($urandom_range(0, 1) == 0) d[31:26] = 6'($urandom_range(0, 16'h2F));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0),
           $urandom, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
